sync_debounce_bank: RTL and testbench
=====================================

# sync_debounce_bank

Parametrised multi-channel synchroniser bringing WIDTH asynchronous single-bit inputs (switches, buttons, external status lines) into the clk domain. Each channel has a configurable-depth flop chain, a per-bit reset value, an optional stability (debounce) filter and registered rise/fall pulse outputs. It replaces ad-hoc fixed two-flop synchronisers at every asynchronous input boundary of the design.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- STAGES, 2, synchroniser flops per channel (≥2; elaboration error if <2)
- RESET_VAL, {WIDTH{1'b0}}, per-bit value loaded into every stage and into level_out on reset
- DEBOUNCE, 0, consecutive stable cycles required before level_out follows sync_out; 0 = filter bypassed
- CNT_W, derived: clog2(DEBOUNCE+1), minimum 1; not user-set
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high; clears all state immediately on assertion
- sig_in  in  WIDTH  asynchronous inputs; no timing relation to clk
- sync_out  out  WIDTH  last synchroniser stage, raw (unfiltered)
- level_out  out  WIDTH  filtered level
- rise_out  out  WIDTH  one-cycle pulse, level_out went 0→1
- fall_out  out  WIDTH  one-cycle pulse, level_out went 1→0
- change_any  out  1  OR-reduction of rise_out | fall_out

## Operation
- Channels are fully independent; no cross-channel coherency is guaranteed (multi-bit buses must not be passed through this block).
- Chain: stage[0] <= sig_in; stage[i] <= stage[i-1]; sync_out = stage[STAGES-1].
- DEBOUNCE = 0: level_out = sync_out (wire, no added latency, no counter).
- DEBOUNCE ≥ 1, per channel, every clk edge:
  - sync_out == level_out: cnt <= 0.
  - sync_out != level_out and cnt == DEBOUNCE-1: level_out <= sync_out, cnt <= 0.
  - otherwise: cnt <= cnt + 1.
  - A glitch shorter than DEBOUNCE cycles resets cnt and never reaches level_out.
- Edge pulses are registered: at the edge where level_out changes, the matching rise_out/fall_out bit is set for exactly one cycle, coincident with the first cycle the new level is visible. For DEBOUNCE = 0 the compare uses stage[STAGES-2] vs sync_out.
- Counter never exceeds DEBOUNCE-1; no wrap-around possible.

## Timing
- Reset (asserted, async): all stages and level_out = RESET_VAL; cnt = 0; sync_out = RESET_VAL; rise_out, fall_out, change_any = 0. No pulses generated by reset assertion or release.
- Reset mid-filtering: pending count discarded; level_out reverts to RESET_VAL with no pulse.
- Latency, sig_in change meeting setup before edge E: sync_out changes after edge E+STAGES-1; level_out after edge E+STAGES-1+DEBOUNCE; pulse in same cycle as level_out change.
- After reset release with sig_in ≠ RESET_VAL, the input propagates normally and produces the corresponding pulse (a genuine transition).
- Back-to-back opposite transitions on one channel are spaced ≥ max(1, DEBOUNCE) cycles apart; rise and fall never assert together on one bit.

## Structure
- Package sync_pkg: clog2 function, CNT_W derivation, parameter-legality checks (STAGES ≥ 2, WIDTH ≥ 1).
- Sub-module sync_debounce_ch: one channel (chain, counter, level, pulse regs), parameters STAGES, DEBOUNCE, RST_BIT; top generates WIDTH instances and ORs pulses into change_any.
- Synchroniser flops carry the team's ASYNC_REG/false-path attributes in sync_debounce_ch only.

## Test plan
- Reset value: RESET_VAL=8'hA5, reset asserted mid-clock → sync_out=level_out=8'hA5 immediately, pulses 0; release with sig_in=8'hA5 → no pulses ever.
- Latency: STAGES=3, DEBOUNCE=0, sig_in[0] 0→1 before edge E → sync_out[0]=1 after E+2, rise_out[0]=1 for one cycle, change_any=1 same cycle.
- Debounce: DEBOUNCE=4, sig_in[2] high 3 cycles then low → level_out[2] stays 0, no pulse; held high 10 cycles → level_out[2]=1 at E+STAGES-1+4, single rise pulse; later low → single fall pulse.
- Independence: toggle sig_in[7] and sig_in[1] at different cycles → only the toggled bits pulse; other bits of level_out unchanged.
- Reset mid-filter: DEBOUNCE=8, sig_in[3] high, reset pulse after 5 cycles of count → level_out[3]=RESET_VAL bit, no pulse; after release, full STAGES-1+8 latency observed again.
- Parameter sweep: STAGES∈{2,4}, DEBOUNCE∈{0,1,15}, WIDTH∈{1,8} random sig_in vs. cycle-accurate reference model; no rise/fall overlap per bit.

Source files
------------

// File: rtl/sync_debounce_bank_pkg.sv
// Shared helpers for the debounced synchroniser bank: counter sizing and
// parameter legality checks used at elaboration time.
package sync_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // A stable-count of DEBOUNCE-1 is the largest value ever held, so
   // DEBOUNCE+1 codes is a safe upper bound; never narrower than one bit.
   function automatic int cntWidth(input int debounce);
      int w;
      w = clog2(debounce + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit paramsLegal(input int width, input int stages, input int debounce);
      return (width >= 1) && (stages >= 2) && (debounce >= 0);
   endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One synchroniser channel: flop chain, optional stability filter and
// registered rise/fall pulses aligned with the first cycle of a new level.
module sync_debounce_ch
   import sync_pkg::*;
#(
   parameter int   STAGES   = 2,
   parameter int   DEBOUNCE = 0,
   parameter logic RST_BIT  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic sync_o,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   (* ASYNC_REG = "TRUE", false_path = "true" *) logic [STAGES-1:0] stage_q;
   logic rise_q;
   logic fall_q;
   logic rise_d;
   logic fall_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= {STAGES{RST_BIT}};
      end else begin
         stage_q <= {stage_q[STAGES-2:0], sig_i};
      end
   end

   assign sync_o = stage_q[STAGES-1];

   generate
      if (DEBOUNCE == 0) begin : g_bypass
         // The next sync value is already sitting in the penultimate stage,
         // so the pulse register lands in the same cycle as the new level.
         assign level_o = sync_o;

         always_comb begin
            rise_d = stage_q[STAGES-2] & ~stage_q[STAGES-1];
            fall_d = ~stage_q[STAGES-2] & stage_q[STAGES-1];
         end
      end else begin : g_filter
         localparam int CNT_W = cntWidth(DEBOUNCE);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             level_q;
         logic             level_d;

         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (sync_o == level_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               level_d = sync_o;
               cnt_d   = '0;
               rise_d  = sync_o;
               fall_d  = ~sync_o;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q   <= '0;
               level_q <= RST_BIT;
            end else begin
               cnt_q   <= cnt_d;
               level_q <= level_d;
            end
         end

         assign level_o = level_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of WIDTH independent synchroniser/debounce channels. Channels are not
// coherent with each other, so multi-bit buses must not pass through here.
module sync_debounce_bank
   import sync_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               DEBOUNCE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_out,
   output logic [WIDTH-1:0] fall_out,
   output logic             change_any
);

   generate
      if (!paramsLegal(WIDTH, STAGES, DEBOUNCE)) begin : g_illegal
         $error("sync_debounce_bank: need WIDTH>=1, STAGES>=2, DEBOUNCE>=0");
      end

      for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
         sync_debounce_ch #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE),
            .RST_BIT  (RESET_VAL[ch])
         ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .sig_i   (sig_in[ch]),
            .sync_o  (sync_out[ch]),
            .level_o (level_out[ch]),
            .rise_o  (rise_out[ch]),
            .fall_o  (fall_out[ch])
         );
      end
   endgenerate

   assign change_any = |(rise_out | fall_out);

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank: four configurations share one clock
// and reset, each exercising latency, filtering, pulses and reset behaviour.
module tb_sync_debounce_bank;

   logic clk;
   logic reset;

   // A: 8 ch, 3 stages, no filter, reset value A5
   logic [7:0] sigA, syncA, levelA, riseA, fallA;
   logic       changeA;
   // B: 8 ch, 2 stages, debounce 4
   logic [7:0] sigB, syncB, levelB, riseB, fallB;
   logic       changeB;
   // C: 1 ch, 4 stages, debounce 8
   logic       sigC, syncC, levelC, riseC, fallC, changeC;
   // D: 2 ch, 2 stages, debounce 1, reset value 2'b10
   logic [1:0] sigD, syncD, levelD, riseD, fallD;
   logic       changeD;

   int compared;
   int mismatched;

   sync_debounce_bank #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5), .DEBOUNCE(0)) dutA (
      .clk(clk), .reset(reset), .sig_in(sigA), .sync_out(syncA), .level_out(levelA),
      .rise_out(riseA), .fall_out(fallA), .change_any(changeA));

   sync_debounce_bank #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h00), .DEBOUNCE(4)) dutB (
      .clk(clk), .reset(reset), .sig_in(sigB), .sync_out(syncB), .level_out(levelB),
      .rise_out(riseB), .fall_out(fallB), .change_any(changeB));

   sync_debounce_bank #(.WIDTH(1), .STAGES(4), .RESET_VAL(1'b0), .DEBOUNCE(8)) dutC (
      .clk(clk), .reset(reset), .sig_in(sigC), .sync_out(syncC), .level_out(levelC),
      .rise_out(riseC), .fall_out(fallC), .change_any(changeC));

   sync_debounce_bank #(.WIDTH(2), .STAGES(2), .RESET_VAL(2'b10), .DEBOUNCE(1)) dutD (
      .clk(clk), .reset(reset), .sig_in(sigD), .sync_out(syncD), .level_out(levelD),
      .rise_out(riseD), .fall_out(fallD), .change_any(changeD));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compared = compared + 1;
      assert (observed === expected) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [1:0] d);
      sigA = a;
      sigB = b;
      sigC = c;
      sigD = d;
   endtask

   // Advance n active edges, returning at the following falling edge.
   task automatic stepClock(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0, 2'b00);

      // Asynchronous reset asserted in the middle of the high phase.
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("rstA_sync", syncA, 8'hA5);
      checkOutput("rstA_level", levelA, 8'hA5);
      checkOutput("rstA_pulses", riseA | fallA, 8'h00);
      checkOutput("rstA_change", 8'(changeA), 8'h00);
      checkOutput("rstD_level", 8'(levelD), 8'h02);
      checkOutput("rstB_level", levelB, 8'h00);

      @(negedge clk);
      applyStimulus(8'hA5, 8'h00, 1'b0, 2'b10);
      stepClock(2);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stepClock(1);
         checkOutput("relA_nochange", 8'(changeA), 8'h00);
         checkOutput("relD_nochange", 8'(changeD), 8'h00);
      end
      checkOutput("relA_level", levelA, 8'hA5);

      // A: bit1 rises, three-stage latency, no filter.
      applyStimulus(8'hA7, 8'h00, 1'b0, 2'b10);
      stepClock(1);
      checkOutput("latA_e0_sync", syncA, 8'hA5);
      stepClock(1);
      checkOutput("latA_e1_sync", syncA, 8'hA5);
      checkOutput("latA_e1_change", 8'(changeA), 8'h00);
      stepClock(1);
      checkOutput("latA_e2_sync", syncA, 8'hA7);
      checkOutput("latA_e2_level", levelA, 8'hA7);
      checkOutput("latA_e2_rise", riseA, 8'h02);
      checkOutput("latA_e2_fall", fallA, 8'h00);
      checkOutput("latA_e2_change", 8'(changeA), 8'h01);
      stepClock(1);
      checkOutput("latA_e3_rise", riseA, 8'h00);
      checkOutput("latA_e3_change", 8'(changeA), 8'h00);

      // A: independence, bit6 rises then bit0 falls one cycle later.
      applyStimulus(8'hE7, 8'h00, 1'b0, 2'b10);
      stepClock(1);
      applyStimulus(8'hE6, 8'h00, 1'b0, 2'b10);
      stepClock(2);
      checkOutput("indA_rise6", riseA, 8'h40);
      checkOutput("indA_fall_none", fallA, 8'h00);
      checkOutput("indA_level1", levelA, 8'hE7);
      stepClock(1);
      checkOutput("indA_rise_none", riseA, 8'h00);
      checkOutput("indA_fall0", fallA, 8'h01);
      checkOutput("indA_level2", levelA, 8'hE6);
      stepClock(1);
      checkOutput("indA_quiet", 8'(changeA), 8'h00);

      // A: bit7 falls.
      applyStimulus(8'h66, 8'h00, 1'b0, 2'b10);
      stepClock(3);
      checkOutput("fallA_fall7", fallA, 8'h80);
      checkOutput("fallA_level", levelA, 8'h66);

      // B: three-cycle glitch on bit2 must be swallowed by the filter.
      applyStimulus(8'h66, 8'h04, 1'b0, 2'b10);
      stepClock(3);
      applyStimulus(8'h66, 8'h00, 1'b0, 2'b10);
      for (int i = 0; i < 6; i++) begin
         stepClock(1);
         checkOutput("glitchB_change", 8'(changeB), 8'h00);
         checkOutput("glitchB_level", levelB, 8'h00);
      end

      // B: held high, level after 1 + 4 edges with a single rise.
      applyStimulus(8'h66, 8'h04, 1'b0, 2'b10);
      stepClock(1);
      checkOutput("holdB_e0_sync", syncB, 8'h00);
      stepClock(1);
      checkOutput("holdB_e1_sync", syncB, 8'h04);
      checkOutput("holdB_e1_level", levelB, 8'h00);
      stepClock(3);
      checkOutput("holdB_e4_level", levelB, 8'h00);
      checkOutput("holdB_e4_rise", riseB, 8'h00);
      stepClock(1);
      checkOutput("holdB_e5_level", levelB, 8'h04);
      checkOutput("holdB_e5_rise", riseB, 8'h04);
      checkOutput("holdB_e5_change", 8'(changeB), 8'h01);
      stepClock(1);
      checkOutput("holdB_e6_rise", riseB, 8'h00);
      for (int i = 0; i < 4; i++) begin
         stepClock(1);
         checkOutput("holdB_steady", 8'(changeB), 8'h00);
      end

      // B: release low, single fall after the same latency.
      applyStimulus(8'h66, 8'h00, 1'b0, 2'b10);
      stepClock(5);
      checkOutput("lowB_e4_level", levelB, 8'h04);
      stepClock(1);
      checkOutput("lowB_e5_level", levelB, 8'h00);
      checkOutput("lowB_e5_fall", fallB, 8'h04);
      checkOutput("lowB_e5_rise", riseB, 8'h00);
      stepClock(1);
      checkOutput("lowB_e6_fall", fallB, 8'h00);

      // D: debounce of one, simultaneous rise on bit0 and fall on bit1.
      applyStimulus(8'h66, 8'h00, 1'b0, 2'b01);
      stepClock(2);
      checkOutput("d1_e1_sync", 8'(syncD), 8'h01);
      checkOutput("d1_e1_level", 8'(levelD), 8'h02);
      stepClock(1);
      checkOutput("d1_e2_level", 8'(levelD), 8'h01);
      checkOutput("d1_e2_rise", 8'(riseD), 8'h01);
      checkOutput("d1_e2_fall", 8'(fallD), 8'h02);
      checkOutput("d1_e2_change", 8'(changeD), 8'h01);
      stepClock(1);
      checkOutput("d1_e3_pulses", 8'(riseD | fallD), 8'h00);

      // C: reset arrives after five counted cycles, then full latency again.
      applyStimulus(8'h66, 8'h00, 1'b1, 2'b01);
      stepClock(4);
      checkOutput("rstC_e3_sync", 8'(syncC), 8'h01);
      checkOutput("rstC_e3_level", 8'(levelC), 8'h00);
      stepClock(5);
      checkOutput("rstC_e8_level", 8'(levelC), 8'h00);
      #2 reset = 1'b1;
      #1;
      checkOutput("rstC_mid_level", 8'(levelC), 8'h00);
      checkOutput("rstC_mid_sync", 8'(syncC), 8'h00);
      checkOutput("rstC_mid_rise", 8'(riseC), 8'h00);
      @(negedge clk);
      reset = 1'b0;
      stepClock(3);
      checkOutput("rstC_f2_sync", 8'(syncC), 8'h00);
      stepClock(1);
      checkOutput("rstC_f3_sync", 8'(syncC), 8'h01);
      stepClock(7);
      checkOutput("rstC_f10_level", 8'(levelC), 8'h00);
      checkOutput("rstC_f10_rise", 8'(riseC), 8'h00);
      stepClock(1);
      checkOutput("rstC_f11_level", 8'(levelC), 8'h01);
      checkOutput("rstC_f11_rise", 8'(riseC), 8'h01);
      checkOutput("rstC_f11_change", 8'(changeC), 8'h01);
      stepClock(1);
      checkOutput("rstC_f12_rise", 8'(riseC), 8'h00);
      checkOutput("rstC_f12_fall", 8'(fallC), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
